// File: rtl/spectrum_bar_display_if.sv
// Bundles the FFT magnitude stream and the LCD pixel request/response signals
// shared between the upstream spectrum stage, the LCD driver and the bar renderer.
interface spectrum_bar_display_if;
  logic        fft_valid;
  logic        fft_ready;
  logic [15:0] fft_data;
  logic        fft_last;
  logic        data_req;
  logic [10:0] pixel_xpos;
  logic [10:0] pixel_ypos;
  logic [15:0] pixel_data;
  logic        frame_swap;

  modport master (
    output fft_valid, fft_data, fft_last, data_req, pixel_xpos, pixel_ypos,
    input  fft_ready, pixel_data, frame_swap
  );

  modport slave (
    input  fft_valid, fft_data, fft_last, data_req, pixel_xpos, pixel_ypos,
    output fft_ready, pixel_data, frame_swap
  );
endinterface

// File: rtl/spectrum_bar_display.sv
// Captures one FFT magnitude frame into a double-buffered height memory and
// renders it as vertical bars, one clock after each LCD pixel request.
//
//   state  | meaning
//   S_IDLE | waiting for the first sample of a new frame
//   S_FILL | writing samples into the hidden bank
//   S_DONE | hidden bank complete, upstream stalled until the display frame ends
module spectrum_bar_display #(
  parameter int          BINS      = 200,
  parameter int          BAR_SHIFT = 2,
  parameter int          H_DISP    = 800,
  parameter int          V_DISP    = 480,
  parameter int          MAG_SHIFT = 4,
  parameter logic [15:0] BAR_COLOR = 16'h07E0,
  parameter logic [15:0] BG_COLOR  = 16'h0000
) (
  input  logic                   lcd_clk,
  input  logic                   sys_rst_n,
  spectrum_bar_display_if.slave  bus
);

  localparam int IDX_W  = $clog2(BINS + 1);
  localparam int ADDR_W = $clog2(BINS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_wr_idx;
  logic [IDX_W-1:0]   w_wr_idx_nxt;
  logic               r_rd_bank;
  logic               r_shown_valid;
  logic               r_frame_swap;
  logic               w_swap;
  logic               w_ready;
  logic               w_wr_en;
  logic               w_frame_end;
  logic [15:0]        w_h_raw;
  logic [8:0]         w_h_sat;
  logic [ADDR_W-1:0]  w_wr_addr;

  logic [8:0]         r_bank0 [BINS];
  logic [8:0]         r_bank1 [BINS];
  logic [8:0]         r_h_rd;

  logic [10:0]        w_rd_col;
  logic               w_oob;
  logic [ADDR_W-1:0]  w_rd_idx;
  logic               r_req_d;
  logic               r_gap;
  logic               r_oob;
  logic [10:0]        r_ypos_d;
  logic               w_bar;

  assign w_frame_end = bus.data_req
                    && (bus.pixel_xpos == 11'(H_DISP - 1))
                    && (bus.pixel_ypos == 11'(V_DISP));

  assign w_h_raw   = bus.fft_data >> MAG_SHIFT;
  assign w_h_sat   = (w_h_raw > 16'(V_DISP)) ? 9'(V_DISP) : w_h_raw[8:0];
  assign w_wr_addr = r_wr_idx[ADDR_W-1:0];

  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state       <= S_IDLE;
      r_wr_idx      <= '0;
      r_rd_bank     <= 1'b0;
      r_shown_valid <= 1'b0;
      r_frame_swap  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_wr_idx     <= w_wr_idx_nxt;
      r_frame_swap <= w_swap;
      if (w_swap) begin
        r_rd_bank     <= ~r_rd_bank;
        r_shown_valid <= 1'b1;
      end
    end
  end

  // IDLE and FILL accept identically; IDLE only marks that no sample has arrived yet.
  always_comb begin
    w_state_nxt  = r_state;
    w_wr_idx_nxt = r_wr_idx;
    w_ready      = 1'b0;
    w_wr_en      = 1'b0;
    w_swap       = 1'b0;
    case (r_state)
      S_IDLE, S_FILL: begin
        w_ready = 1'b1;
        if (bus.fft_valid) begin
          w_wr_en = (r_wr_idx < IDX_W'(BINS));
          if (bus.fft_last) begin
            w_wr_idx_nxt = '0;
            w_state_nxt  = S_DONE;
          end else begin
            if (r_wr_idx < IDX_W'(BINS)) begin
              w_wr_idx_nxt = r_wr_idx + IDX_W'(1);
            end
            w_state_nxt = S_FILL;
          end
        end
      end
      S_DONE: begin
        if (w_frame_end) begin
          w_swap      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_rd_col = bus.pixel_xpos >> BAR_SHIFT;
  assign w_oob    = (w_rd_col >= 11'(BINS));
  assign w_rd_idx = w_oob ? '0 : w_rd_col[ADDR_W-1:0];

  // Height RAM is deliberately unreset; shown_valid masks it until the first swap.
  always_ff @(posedge lcd_clk) begin
    if (w_wr_en) begin
      if (r_rd_bank) begin
        r_bank0[w_wr_addr] <= w_h_sat;
      end else begin
        r_bank1[w_wr_addr] <= w_h_sat;
      end
    end
    if (bus.data_req) begin
      r_h_rd <= r_rd_bank ? r_bank1[w_rd_idx] : r_bank0[w_rd_idx];
    end
  end

  always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_req_d  <= 1'b0;
      r_gap    <= 1'b0;
      r_oob    <= 1'b0;
      r_ypos_d <= '0;
    end else begin
      r_req_d <= bus.data_req;
      if (bus.data_req) begin
        r_ypos_d <= bus.pixel_ypos;
        r_gap    <= &bus.pixel_xpos[BAR_SHIFT-1:0];
        r_oob    <= w_oob;
      end
    end
  end

  // ypos_d >= V_DISP + 1 - h, rearranged so nothing can underflow.
  assign w_bar = r_req_d && r_shown_valid && !r_gap && !r_oob
              && (r_h_rd != 9'd0)
              && (({1'b0, r_ypos_d} + {3'b000, r_h_rd}) >= 12'(V_DISP + 1));

  assign bus.pixel_data = w_bar ? BAR_COLOR : BG_COLOR;
  assign bus.fft_ready  = w_ready;
  assign bus.frame_swap = r_frame_swap;

endmodule
